// File: rtl/picorv32_ahb_single_master.sv
`default_nettype none
// ============================================================================
// Module      : picorv32_ahb_single_master
// Description : Single-outstanding AHB 2.0 master for the PicoRV32 subsystem.
//               It takes one request from the memory adapter and issues one
//               SINGLE transfer on the GRLIB AHB bus. It handles arbitration,
//               wait states, and ERROR, RETRY and SPLIT responses.
// Revision    : 1.0 - initial release
// ============================================================================
module picorv32_ahb_single_master #(
  parameter int RETRY_LIMIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  // Upstream request interface
  input  logic        ui_read,
  input  logic        ui_write,
  input  logic [31:0] ui_addr,
  input  logic [2:0]  ui_size,
  input  logic [31:0] ui_wdata,
  input  logic [3:0]  ui_prot,
  input  logic        ui_lock,
  output logic        ui_next,
  output logic        ui_ready,
  output logic [31:0] ui_rdata,
  output logic        ui_error,
  // AHB master interface
  output logic        hbusreq,
  input  logic        hgrant,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [3:0]  hprot,
  output logic        hmastlock,
  output logic [31:0] hwdata,
  input  logic        hready,
  input  logic [1:0]  hresp,
  input  logic [31:0] hrdata
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DATA  = 3'd3,
    ST_RETRY = 3'd4
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [7:0] RETRY_MAX     = 8'(RETRY_LIMIT);
  localparam bit         RETRY_BOUNDED = (RETRY_LIMIT != 0);

  state_t      state;
  state_t      state_nxt;

  // Holding registers for the request being serviced
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [31:0] wdata_q;
  logic [3:0]  prot_q;
  logic        lock_q;
  logic        write_q;

  logic [7:0]  retry_cnt;
  logic        next_done;   // ui_next already given for this request

  logic        req_valid;
  logic        req_illegal;
  logic        accept;

  // Decisions produced by the next-state logic, registered below
  logic        next_set;
  logic        ready_set;
  logic        error_set;
  logic        rdata_cap;
  logic        retry_inc;

  assign hburst    = 3'b000;
  assign req_valid = ui_read | ui_write;

  // Sizes above word, or sub-word accesses not naturally aligned, are refused
  assign req_illegal = (ui_size > 3'd2) ||
                       ((ui_size == 3'd1) && ui_addr[0]) ||
                       ((ui_size == 3'd2) && (ui_addr[1:0] != 2'b00));

  // The ui_ready cycle is excluded so a requester still holding its strobe
  // while a response pulse is out is not mistaken for a second request.
  assign accept = (state == ST_IDLE) && req_valid && !ui_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, response decisions and bus outputs
  always_comb begin
    state_nxt = state;
    next_set  = 1'b0;
    ready_set = 1'b0;
    error_set = 1'b0;
    rdata_cap = 1'b0;
    retry_inc = 1'b0;
    hbusreq   = 1'b0;
    htrans    = HTRANS_IDLE;
    haddr     = 32'h0;
    hwrite    = 1'b0;
    hsize     = 3'b000;
    hprot     = 4'h0;
    hmastlock = 1'b0;
    hwdata    = 32'h0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_illegal) begin
            next_set  = 1'b1;
            ready_set = 1'b1;
            error_set = 1'b1;
          end else begin
            state_nxt = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        hbusreq = 1'b1;
        if (hgrant && hready) begin
          state_nxt = ST_ADDR;
        end
      end

      ST_ADDR: begin
        hbusreq   = lock_q;
        htrans    = HTRANS_NONSEQ;
        haddr     = addr_q;
        hwrite    = write_q;
        hsize     = size_q;
        hprot     = prot_q;
        hmastlock = lock_q;
        if (hready) begin
          // A reissued transfer after RETRY/SPLIT is not re-announced upstream
          next_set  = !next_done;
          state_nxt = ST_DATA;
        end
      end

      ST_DATA: begin
        hbusreq = lock_q;
        if (write_q) begin
          hwdata = wdata_q;
        end
        if (hready) begin
          // Completion; a non-OKAY response with hready high is malformed
          // and reported as an error rather than silently accepted.
          ready_set = 1'b1;
          state_nxt = ST_IDLE;
          if (hresp != HRESP_OKAY) begin
            error_set = 1'b1;
          end else begin
            rdata_cap = !write_q;
          end
        end else if (hresp == HRESP_ERROR) begin
          // First ERROR cycle; the pulse lands on the closing hready cycle
          ready_set = 1'b1;
          error_set = 1'b1;
          state_nxt = ST_IDLE;
        end else if (hresp[1]) begin
          // RETRY or SPLIT first cycle
          retry_inc = 1'b1;
          state_nxt = ST_RETRY;
        end
      end

      ST_RETRY: begin
        hbusreq = lock_q;
        if (hready) begin
          if (RETRY_BOUNDED && (retry_cnt == RETRY_MAX)) begin
            ready_set = 1'b1;
            error_set = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_REQ;
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Capture the request into the holding registers on acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= 32'h0;
      size_q  <= 3'b000;
      wdata_q <= 32'h0;
      prot_q  <= 4'h0;
      lock_q  <= 1'b0;
      write_q <= 1'b0;
    end else if (accept) begin
      addr_q  <= ui_addr;
      size_q  <= ui_size;
      wdata_q <= ui_wdata;
      prot_q  <= ui_prot;
      lock_q  <= ui_lock;
      write_q <= ui_write;
    end
  end

  // Saturating retry counter and once-per-request ui_next tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retry_cnt <= 8'h00;
      next_done <= 1'b0;
    end else if (state == ST_IDLE) begin
      retry_cnt <= 8'h00;
      next_done <= 1'b0;
    end else begin
      if (retry_inc && (retry_cnt != 8'hFF)) begin
        retry_cnt <= retry_cnt + 8'h01;
      end
      if (next_set) begin
        next_done <= 1'b1;
      end
    end
  end

  // Registered upstream pulses and read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ui_next  <= 1'b0;
      ui_ready <= 1'b0;
      ui_error <= 1'b0;
      ui_rdata <= 32'h0;
    end else begin
      ui_next  <= next_set;
      ui_ready <= ready_set;
      ui_error <= error_set;
      if (rdata_cap) begin
        ui_rdata <= hrdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_picorv32_ahb_single_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_picorv32_ahb_single_master
// Description : Directed bench for picorv32_ahb_single_master. Completions are
//               checked by a scoreboard fed at request time; bus-phase and
//               timing details are checked inline. A second instance with a
//               retry limit of one runs on the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_picorv32_ahb_single_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        ui_read, ui_write, ui_lock;
  logic [31:0] ui_addr, ui_wdata;
  logic [2:0]  ui_size;
  logic [3:0]  ui_prot;
  logic        hgrant, hready;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  // Instance with unbounded retries
  logic        ui_next, ui_ready, ui_error, hbusreq, hwrite, hmastlock;
  logic [31:0] ui_rdata, haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;

  // Instance with a retry limit of one
  logic        l_ui_next, l_ui_ready, l_ui_error, l_hbusreq, l_hwrite, l_hmastlock;
  logic [31:0] l_ui_rdata, l_haddr, l_hwdata;
  logic [1:0]  l_htrans;
  logic [2:0]  l_hsize, l_hburst;
  logic [3:0]  l_hprot;

  picorv32_ahb_single_master #(.RETRY_LIMIT(0)) dut (
    .clk(clk), .reset(reset),
    .ui_read(ui_read), .ui_write(ui_write), .ui_addr(ui_addr), .ui_size(ui_size),
    .ui_wdata(ui_wdata), .ui_prot(ui_prot), .ui_lock(ui_lock),
    .ui_next(ui_next), .ui_ready(ui_ready), .ui_rdata(ui_rdata), .ui_error(ui_error),
    .hbusreq(hbusreq), .hgrant(hgrant), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
    .hmastlock(hmastlock), .hwdata(hwdata), .hready(hready), .hresp(hresp),
    .hrdata(hrdata)
  );

  picorv32_ahb_single_master #(.RETRY_LIMIT(1)) dut_lim (
    .clk(clk), .reset(reset),
    .ui_read(ui_read), .ui_write(ui_write), .ui_addr(ui_addr), .ui_size(ui_size),
    .ui_wdata(ui_wdata), .ui_prot(ui_prot), .ui_lock(ui_lock),
    .ui_next(l_ui_next), .ui_ready(l_ui_ready), .ui_rdata(l_ui_rdata), .ui_error(l_ui_error),
    .hbusreq(l_hbusreq), .hgrant(hgrant), .haddr(l_haddr), .htrans(l_htrans),
    .hwrite(l_hwrite), .hsize(l_hsize), .hburst(l_hburst), .hprot(l_hprot),
    .hmastlock(l_hmastlock), .hwdata(l_hwdata), .hready(hready), .hresp(hresp),
    .hrdata(hrdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        error;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_next = 0;
  int   n_nonseq = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request; it is sampled at the next rising edge
  task automatic issue(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd);
    ui_read  = !wr;
    ui_write = wr;
    ui_addr  = a;
    ui_size  = sz;
    ui_wdata = wd;
  endtask

  task automatic drop();
    ui_read  = 1'b0;
    ui_write = 1'b0;
  endtask

  // Scoreboard monitor: every completion pops one expected response
  always @(negedge clk) begin
    if (!reset) begin
      if (ui_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected: ui_ready=1 with no expected response (t=%0t)", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_rdata", ui_rdata, e.rdata);
          check("sb_error", {31'h0, ui_error}, {31'h0, e.error});
        end
      end
      if (ui_next) n_next++;
      if (htrans == 2'b10) n_nonseq++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int   next0, nonseq0;
    logic got;
    reset = 1'b1;
    drop();
    ui_addr = 32'h0; ui_size = 3'd0; ui_wdata = 32'h0; ui_prot = 4'h3; ui_lock = 1'b0;
    hgrant = 1'b1; hready = 1'b1; hresp = 2'b00; hrdata = 32'h0;
    tick(); tick();

    // Reset state
    check("rst_htrans",  {30'h0, htrans}, 32'h0);
    check("rst_hbusreq", {31'h0, hbusreq}, 32'h0);
    check("rst_hburst",  {29'h0, hburst}, 32'h0);
    check("rst_pulses",  {30'h0, ui_next, ui_ready}, 32'h0);
    check("rst_rdata",   ui_rdata, 32'h0);
    reset = 1'b0;
    tick();

    // 1: word read, grant parked, zero wait states
    issue(1'b0, 32'h4000_0004, 3'd2, 32'h0);
    exp_q.push_back('{32'hDEAD_BEEF, 1'b0});
    tick();                                           // cycle 1
    drop();
    check("t1_c1_hbusreq", {31'h0, hbusreq}, 32'h1);
    check("t1_c1_htrans",  {30'h0, htrans}, 32'h0);
    tick();                                           // cycle 2
    check("t1_c2_htrans", {30'h0, htrans}, 32'h2);
    check("t1_c2_haddr",  haddr, 32'h4000_0004);
    check("t1_c2_hsize",  {29'h0, hsize}, 32'h2);
    check("t1_c2_hwrite", {31'h0, hwrite}, 32'h0);
    check("t1_c2_hprot",  {28'h0, hprot}, 32'h3);
    hrdata = 32'hDEAD_BEEF;
    tick();                                           // cycle 3
    check("t1_c3_next",   {31'h0, ui_next}, 32'h1);
    check("t1_c3_htrans", {30'h0, htrans}, 32'h0);
    check("t1_c3_ready",  {31'h0, ui_ready}, 32'h0);
    tick();                                           // cycle 4
    check("t1_c4_ready",  {31'h0, ui_ready}, 32'h1);
    check("t1_c4_next",   {31'h0, ui_next}, 32'h0);
    hrdata = 32'h5555_5555;
    tick();
    check("t1_c5_ready",  {31'h0, ui_ready}, 32'h0);

    // 2: byte write, grant late by 5 cycles, 2 data wait states
    hgrant = 1'b0;
    issue(1'b1, 32'h4000_0003, 3'd0, 32'hAB00_0000);
    exp_q.push_back('{32'hDEAD_BEEF, 1'b0});
    tick();
    drop();
    for (int i = 0; i < 5; i++) begin
      check("t2_busreq_wait", {30'h0, hbusreq, htrans[1]}, 32'h2);
      if (i == 4) hgrant = 1'b1;
      tick();
    end
    check("t2_addr_htrans", {30'h0, htrans}, 32'h2);
    check("t2_addr_hsize",  {29'h0, hsize}, 32'h0);
    check("t2_addr_hwrite", {31'h0, hwrite}, 32'h1);
    check("t2_addr_haddr",  haddr, 32'h4000_0003);
    tick();
    check("t2_next", {31'h0, ui_next}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      hready = (i == 2);
      check("t2_hwdata", hwdata, 32'hAB00_0000);
      check("t2_no_ready", {31'h0, ui_ready}, 32'h0);
      tick();
    end
    check("t2_ready", {31'h0, ui_ready}, 32'h1);
    tick();

    // 3: ERROR response to a read
    issue(1'b0, 32'h4000_0008, 3'd2, 32'h0);
    exp_q.push_back('{32'hDEAD_BEEF, 1'b1});
    hrdata = 32'h1234_5678;
    tick(); drop();
    tick(); tick();                                   // cycle 3: data phase
    hready = 1'b0; hresp = 2'b01;
    check("t3_no_ready_first", {31'h0, ui_ready}, 32'h0);
    tick();
    hready = 1'b1;
    check("t3_ready_err", {30'h0, ui_ready, ui_error}, 32'h3);
    tick();
    hresp = 2'b00;
    check("t3_ready_single", {31'h0, ui_ready}, 32'h0);
    tick();

    // 4: RETRY twice then OKAY (unbounded); limit-1 instance errors at once
    next0 = n_next; nonseq0 = n_nonseq;
    issue(1'b0, 32'h4000_000C, 3'd2, 32'h0);
    exp_q.push_back('{32'hCAFE_F00D, 1'b0});
    tick(); drop();
    for (int r = 0; r < 2; r++) begin
      tick();                                         // ADDR
      check("t4_retry_haddr", haddr, 32'h4000_000C);
      tick();                                         // DATA, RETRY first cycle
      hready = 1'b0; hresp = 2'b10;
      tick();                                         // second response cycle
      check("t4_retry_htrans", {30'h0, htrans}, 32'h0);
      hready = 1'b1;
      tick();                                         // back in REQ
      hresp = 2'b00;
      check("t4_reissue_busreq", {31'h0, hbusreq}, 32'h1);
      if (r == 0) begin
        check("t4_lim_ready_err", {30'h0, l_ui_ready, l_ui_error}, 32'h3);
        check("t4_lim_busreq", {31'h0, l_hbusreq}, 32'h0);
      end
    end
    hrdata = 32'hCAFE_F00D;
    tick();                                           // ADDR
    tick();                                           // DATA, OKAY
    check("t4_no_early_ready", {31'h0, ui_ready}, 32'h0);
    tick();
    check("t4_ready", {30'h0, ui_ready, ui_error}, 32'h2);
    tick();
    check("t4_next_once", n_next - next0, 1);
    check("t4_three_nonseq", n_nonseq - nonseq0, 3);

    // 5: misaligned halfword, held one extra cycle by the requester
    issue(1'b0, 32'h0000_1001, 3'd1, 32'h0);
    exp_q.push_back('{32'hCAFE_F00D, 1'b1});
    tick();
    check("t5_pulses", {29'h0, ui_next, ui_ready, ui_error}, 32'h7);
    check("t5_bus_idle", {29'h0, hbusreq, htrans}, 32'h0);
    tick();
    drop();
    check("t5_bus_still_idle", {29'h0, hbusreq, htrans}, 32'h0);
    check("t5_single_pulse", {30'h0, ui_next, ui_ready}, 32'h0);
    tick();

    // 6: reset during DATA, then a fresh read
    issue(1'b0, 32'h4000_0010, 3'd2, 32'h0);
    tick(); drop();
    tick(); tick();                                   // DATA
    hready = 1'b0;
    reset = 1'b1;
    #1;
    check("t6_rst_bus", {29'h0, hbusreq, htrans}, 32'h0);
    check("t6_rst_pulses", {30'h0, ui_next, ui_ready}, 32'h0);
    check("t6_rst_rdata", ui_rdata, 32'h0);
    tick(); tick();
    check("t6_rst_hold", {28'h0, hbusreq, htrans, ui_ready}, 32'h0);
    reset = 1'b0;
    hready = 1'b1;
    tick();
    hrdata = 32'h0BAD_F00D;
    issue(1'b0, 32'h4000_0020, 3'd2, 32'h0);
    exp_q.push_back('{32'h0BAD_F00D, 1'b0});
    tick(); drop();
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (ui_ready) got = 1'b1;
    end
    check("t6_fresh_done", {31'h0, got}, 32'h1);
    tick(); tick();

    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
